// File: rtl/grid_clear_engine.sv
// Playfield occupancy memory (ROWS x COLS bits) with a line-clear engine that
// removes full rows, compacts the remaining rows downward and reports the count.
module grid_clear_engine #(
    parameter int COLS = 10,
    parameter int ROWS = 20,
    localparam int XW = $clog2(COLS),
    localparam int YW = $clog2(ROWS),
    localparam int CW = $clog2(ROWS + 1)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [XW-1:0] x,
    input  logic [YW-1:0] y,
    input  logic          enable_reading,
    input  logic          enable_writing,
    input  logic          cell_in,
    output logic          cell_out,
    input  logic          clear_start,
    output logic          clear_busy,
    output logic          clear_done,
    output logic [CW-1:0] lines_cleared,
    output logic          top_occupied
);

    localparam logic [XW-1:0] XMAX = XW'(COLS - 1);
    localparam logic [YW-1:0] YMAX = YW'(ROWS - 1);

    typedef enum logic [1:0] {IDLE, COMPACT, FILL, DONE} state_t;

    state_t                     state;
    logic [ROWS-1:0][COLS-1:0]  grid;
    logic [YW-1:0]              src;
    logic [YW-1:0]              dst;
    logic [CW-1:0]              cnt;
    logic [CW-1:0]              cnt_nx;
    logic                       row_full;
    logic                       in_range;

    assign in_range     = (x <= XMAX) && (y <= YMAX);
    assign row_full     = &grid[src];
    assign cnt_nx       = cnt + {{(CW-1){1'b0}}, row_full};
    assign cell_out     = (enable_reading && !clear_busy && in_range) ? grid[y][x] : 1'b0;
    assign top_occupied = |grid[0];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            grid          <= '0;
            state         <= IDLE;
            src           <= '0;
            dst           <= '0;
            cnt           <= '0;
            clear_busy    <= 1'b0;
            clear_done    <= 1'b0;
            lines_cleared <= '0;
        end else begin
            clear_done <= 1'b0;
            // Cell writes only reach the grid outside COMPACT/FILL, so they never
            // collide with the engine's row moves.
            if (enable_writing && !clear_busy && in_range)
                grid[y][x] <= cell_in;

            case (state)
                IDLE: begin
                    if (clear_start) begin
                        state      <= COMPACT;
                        src        <= YMAX;
                        dst        <= YMAX;
                        cnt        <= '0;
                        clear_busy <= 1'b1;
                    end
                end
                COMPACT: begin
                    if (!row_full) begin
                        grid[dst] <= grid[src];
                        if (dst != '0)
                            dst <= dst - 1'b1;
                    end
                    cnt <= cnt_nx;
                    if (src == '0) begin
                        if (cnt_nx == '0) begin
                            state         <= DONE;
                            clear_busy    <= 1'b0;
                            clear_done    <= 1'b1;
                            lines_cleared <= cnt_nx;
                        end else begin
                            state <= FILL;
                        end
                    end else begin
                        src <= src - 1'b1;
                    end
                end
                FILL: begin
                    // dst enters FILL at cnt-1, so this runs exactly cnt cycles.
                    grid[dst] <= '0;
                    if (dst == '0) begin
                        state         <= DONE;
                        clear_busy    <= 1'b0;
                        clear_done    <= 1'b1;
                        lines_cleared <= cnt;
                    end else begin
                        dst <= dst - 1'b1;
                    end
                end
                DONE: state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_grid_clear_engine.sv
// Bench for grid_clear_engine: table-driven cell access vectors, a reference grid
// model, and a scoreboard of expected clear-pass results.
module tb_grid_clear_engine;

    localparam int COLS = 10;
    localparam int ROWS = 20;
    localparam int XW = $clog2(COLS);
    localparam int YW = $clog2(ROWS);
    localparam int CW = $clog2(ROWS + 1);

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [XW-1:0] x = '0;
    logic [YW-1:0] y = '0;
    logic          enable_reading = 1'b0;
    logic          enable_writing = 1'b0;
    logic          cell_in = 1'b0;
    logic          cell_out;
    logic          clear_start = 1'b0;
    logic          clear_busy;
    logic          clear_done;
    logic [CW-1:0] lines_cleared;
    logic          top_occupied;

    grid_clear_engine #(.COLS(COLS), .ROWS(ROWS)) dut (
        .clk(clk), .rst(rst), .x(x), .y(y),
        .enable_reading(enable_reading), .enable_writing(enable_writing),
        .cell_in(cell_in), .cell_out(cell_out),
        .clear_start(clear_start), .clear_busy(clear_busy), .clear_done(clear_done),
        .lines_cleared(lines_cleared), .top_occupied(top_occupied)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;
    bit mdl[ROWS][COLS];

    typedef struct {
        int lines;
        int lat;
    } exp_t;
    exp_t sbq[$];

    typedef struct {
        int x;
        int y;
        bit we;
        bit re;
        bit din;
        bit exp_out;
    } vec_t;

    task automatic check(string name, int act, int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic mdl_reset();
        for (int r = 0; r < ROWS; r++)
            for (int c = 0; c < COLS; c++)
                mdl[r][c] = 1'b0;
    endtask

    task automatic mdl_clear();
        bit tmp[ROWS][COLS];
        int d;
        bit full;
        d = ROWS - 1;
        for (int r = 0; r < ROWS; r++)
            for (int c = 0; c < COLS; c++)
                tmp[r][c] = 1'b0;
        for (int s = ROWS - 1; s >= 0; s--) begin
            full = 1'b1;
            for (int c = 0; c < COLS; c++)
                if (!mdl[s][c]) full = 1'b0;
            if (!full) begin
                for (int c = 0; c < COLS; c++)
                    tmp[d][c] = mdl[s][c];
                d--;
            end
        end
        mdl = tmp;
    endtask

    // Called with time just after a posedge; leaves it just after the next posedge.
    task automatic write_cell(int cx, int cy, bit v);
        x = XW'(cx);
        y = YW'(cy);
        cell_in = v;
        enable_writing = 1'b1;
        @(posedge clk);
        #1;
        enable_writing = 1'b0;
        if (cx < COLS && cy < ROWS) mdl[cy][cx] = v;
    endtask

    task automatic fill_row(int r);
        for (int c = 0; c < COLS; c++) write_cell(c, r, 1'b1);
    endtask

    task automatic read_cell(int cx, int cy, output bit v);
        x = XW'(cx);
        y = YW'(cy);
        enable_reading = 1'b1;
        #1;
        v = cell_out;
        enable_reading = 1'b0;
    endtask

    task automatic check_grid(string name);
        int bad;
        bit v;
        bad = 0;
        for (int r = 0; r < ROWS; r++)
            for (int c = 0; c < COLS; c++) begin
                read_cell(c, r, v);
                if (v !== mdl[r][c]) bad++;
            end
        check(name, bad, 0);
    endtask

    // One pass: expected result goes on the scoreboard at start, comes off at done.
    task automatic run_clear(string name, int exp_lines, bit stray_traffic);
        exp_t e;
        int lat;
        int busy_n;
        bit got;
        bit v;
        e.lines = exp_lines;
        e.lat   = ROWS + exp_lines;
        sbq.push_back(e);
        clear_start = 1'b1;
        @(posedge clk);
        #1;
        clear_start = 1'b0;
        lat = 0;
        busy_n = 0;
        got = 1'b0;
        for (int i = 1; i <= 100; i++) begin
            if (clear_busy) busy_n++;
            if (stray_traffic && i == 3) begin
                read_cell(4, 1, v);
                check({name, " read_blocked_busy"}, v, 0);
            end
            if (stray_traffic && i >= 4 && i <= 8) begin
                x = 4'd9; y = 5'd5; cell_in = 1'b1; enable_writing = 1'b1;
                clear_start = (i == 6);
            end
            @(posedge clk);
            #1;
            enable_writing = 1'b0;
            clear_start = 1'b0;
            if (clear_done) begin
                lat = i;
                got = 1'b1;
                break;
            end
        end
        check({name, " done_seen"}, got, 1);
        e = sbq.pop_front();
        check({name, " latency"}, lat, e.lat);
        check({name, " busy_cycles"}, busy_n, e.lat);
        check({name, " busy_in_done"}, clear_busy, 0);
        @(posedge clk);
        #1;
        check({name, " done_one_cycle"}, clear_done, 0);
        check({name, " lines_cleared"}, lines_cleared, e.lines);
        mdl_clear();
    endtask

    initial begin
        vec_t vt[12];
        bit v;
        int busy_seen;

        vt[0]  = '{x: 3,  y: 7,  we: 0, re: 1, din: 0, exp_out: 0};
        vt[1]  = '{x: 3,  y: 7,  we: 1, re: 1, din: 1, exp_out: 0};
        vt[2]  = '{x: 3,  y: 7,  we: 0, re: 1, din: 0, exp_out: 1};
        vt[3]  = '{x: 3,  y: 7,  we: 0, re: 0, din: 0, exp_out: 0};
        vt[4]  = '{x: 12, y: 7,  we: 1, re: 1, din: 1, exp_out: 0};
        vt[5]  = '{x: 0,  y: 20, we: 1, re: 1, din: 1, exp_out: 0};
        vt[6]  = '{x: 9,  y: 19, we: 1, re: 1, din: 1, exp_out: 0};
        vt[7]  = '{x: 9,  y: 19, we: 0, re: 1, din: 0, exp_out: 1};
        vt[8]  = '{x: 9,  y: 19, we: 1, re: 1, din: 0, exp_out: 1};
        vt[9]  = '{x: 9,  y: 19, we: 0, re: 1, din: 0, exp_out: 0};
        vt[10] = '{x: 3,  y: 7,  we: 1, re: 1, din: 0, exp_out: 1};
        vt[11] = '{x: 3,  y: 7,  we: 0, re: 1, din: 0, exp_out: 0};

        mdl_reset();
        repeat (2) @(posedge clk);
        #1;
        check("reset busy", clear_busy, 0);
        check("reset done", clear_done, 0);
        check("reset lines", lines_cleared, 0);
        rst = 1'b0;
        @(posedge clk);
        #1;
        check_grid("reset grid");
        check("reset top", top_occupied, 0);

        // Cell access vectors: read checked before the edge that performs the write.
        for (int i = 0; i < 12; i++) begin
            x = XW'(vt[i].x);
            y = YW'(vt[i].y);
            enable_writing = vt[i].we;
            enable_reading = vt[i].re;
            cell_in = vt[i].din;
            #1;
            check($sformatf("vec%0d cell_out", i), cell_out, vt[i].exp_out);
            @(posedge clk);
            #1;
            enable_writing = 1'b0;
            enable_reading = 1'b0;
        end
        check_grid("vec grid untouched");

        write_cell(4, 0, 1'b1);
        check("top set", top_occupied, 1);
        write_cell(4, 0, 1'b0);
        check("top clear", top_occupied, 0);

        // Single full row at the bottom
        fill_row(19);
        write_cell(0, 18, 1'b1);
        run_clear("one_line", 1, 1'b0);
        check_grid("one_line grid");
        read_cell(0, 19, v);
        check("one_line (0,19)", v, 1);

        // Two non-adjacent full rows with cells in between
        write_cell(0, 19, 1'b0);
        fill_row(19);
        fill_row(17);
        write_cell(5, 18, 1'b1);
        write_cell(2, 16, 1'b1);
        run_clear("two_lines", 2, 1'b0);
        check_grid("two_lines grid");
        read_cell(5, 19, v);
        check("two_lines (5,19)", v, 1);
        read_cell(2, 18, v);
        check("two_lines (2,18)", v, 1);

        // Empty grid then completely full grid
        write_cell(5, 19, 1'b0);
        write_cell(2, 18, 1'b0);
        run_clear("empty", 0, 1'b0);
        check_grid("empty grid");
        for (int r = 0; r < ROWS; r++) fill_row(r);
        check("full top", top_occupied, 1);
        run_clear("all_full", ROWS, 1'b0);
        check_grid("all_full grid");
        check("all_full top", top_occupied, 0);

        // Writes, reads and a second start during a pass are all ignored
        fill_row(19);
        write_cell(4, 0, 1'b1);
        write_cell(4, 1, 1'b1);
        run_clear("busy_ignore", 1, 1'b1);
        check_grid("busy_ignore grid");
        busy_seen = 0;
        for (int i = 0; i < 30; i++) begin
            @(posedge clk);
            #1;
            if (clear_busy) busy_seen++;
        end
        check("no_queued_pass", busy_seen, 0);

        // Asynchronous reset in the middle of COMPACT
        fill_row(19);
        fill_row(0);
        clear_start = 1'b1;
        @(posedge clk);
        #1;
        clear_start = 1'b0;
        repeat (5) @(posedge clk);
        #3;
        check("pre_rst busy", clear_busy, 1);
        rst = 1'b1;
        #1;
        check("rst busy async", clear_busy, 0);
        check("rst lines", lines_cleared, 0);
        check("rst top", top_occupied, 0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        mdl_reset();
        check_grid("rst grid");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL timeout: got no finish expected finish");
        $fatal(1, "timeout");
    end

endmodule
